mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Multi-cycle data-memory access unit between the datapath and a byte-wide, single-port data memory with a ready handshake. It consumes the MemRead and MemWrite strobes issued by the control unit, together with funct3, the ALU-computed address and the store data. It then performs LB/LH/LW/LBU/LHU loads and SB/SH/SW stores as sequential little-endian byte transactions, stalling the pipeline until the access completes. Misaligned and illegal accesses are reported as an error and never touch memory.

## Interface
- ADDR_W, 32, address width for both the CPU side and the memory side.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- MemRead  in  1  load request from the control unit.
- MemWrite  in  1  store request from the control unit.
- funct3  in  3  access size and sign: 0 LB/SB, 1 LH/SH, 2 LW/SW, 4 LBU, 5 LHU.
- addr  in  ADDR_W  byte address (ALU result).
- wdata  in  32  store data (rs2).
- stall  out  1  pipeline hold; the request inputs must be held stable while it is 1.
- done  out  1  one-cycle completion pulse.
- err  out  1  valid with done; 1 means misaligned or illegal access, no memory activity.
- rdata  out  32  extended load result; valid with done when MemRead and !err.
- mem_addr  out  ADDR_W  memory byte address.
- mem_wdata  out  8  memory write byte.
- mem_re  out  1  memory read strobe.
- mem_we  out  1  memory write strobe.
- mem_rdata  in  8  memory read byte; valid when mem_ready=1.
- mem_ready  in  1  memory completes the current byte this cycle.

## Operation
- **State machine:** IDLE, ACCESS, DONE.
- **Request:** a request exists in IDLE when MemRead|MemWrite.
- **Illegal request:** any one of the following makes the request illegal:
  - MemRead and MemWrite are both 1.
  - Load funct3 is 3, 6 or 7.
  - Store funct3 is greater than 2.
  - The access is misaligned: halfword with addr[0]=1, or word with addr[1:0]≠0.
- **IDLE:**
  - A legal request latches addr, wdata, funct3 and direction, clears the byte counter cnt and moves to ACCESS.
  - An illegal request moves directly to DONE with the err flag set.
  - No request: stay in IDLE.
- **Byte count:** N = 1, 2 or 4 for byte, halfword or word.
- **ACCESS:**
  - mem_re (load) or mem_we (store) is held at 1.
  - mem_addr = latched addr + cnt, modulo 2^ADDR_W.
  - mem_wdata = latched wdata byte cnt.
  - On a cycle with mem_ready=1:
    - A load captures mem_rdata into byte lane cnt.
    - If cnt=N-1, go to DONE; otherwise cnt increments.
  - A cycle with mem_ready=0 changes nothing.
- **DONE:**
  - done=1 for exactly one cycle, then return to IDLE. No request is accepted in DONE.
  - rdata: LB/LH sign-extend from bit 7/15, LBU/LHU zero-extend, LW passes all 32 bits. rdata is 0 for stores and for errors.
- **stall:** stall = (IDLE and request present) or ACCESS. It is combinational and 0 in DONE, so the pipeline advances at the end of the DONE cycle.
- **Memory strobes:** mem_re, mem_we, mem_addr and mem_wdata are 0 outside ACCESS. mem_re and mem_we are never both 1.
- **rdata storage:** rdata is held in a register and cleared on entry to ACCESS.

## Timing
- **Reset:**
  - rst_n=0 at a rising edge forces IDLE and cnt=0, and clears err, the latched request and the load buffer.
  - While in reset, all outputs (stall, done, err, rdata, mem_*) are 0.
- **Reset mid-ACCESS:** the strobe drops at that edge and a partial store is not completed. The datapath must reissue the access.
- **Latency, legal request accepted at edge E** (request visible in the cycle before E):
  - With mem_ready tied 1, ACCESS lasts N cycles after E and done is high in cycle N+1 after E.
  - Total stall cycles = N+1, counting the request cycle.
  - Each mem_ready=0 cycle adds exactly one cycle.
- **Illegal request:** done and err are high in the cycle right after the request cycle; 1 stall cycle.
- **Back-to-back requests:** the minimum gap is one IDLE cycle after DONE. A request present during DONE is evaluated in the following IDLE cycle.
- **Address wrap:** mem_addr wraps across 0xFFFF_FFFF → 0x0000_0000 for unaligned-legal byte sequences. This occurs only at the end of an aligned word, where it is impossible when aligned; the adder must still be modular.

## Test plan
- **LW sign/endianness:**
  - Stimulus: memory at 0x100..0x103 = 0x78,0x56,0x34,0x12; LW addr 0x100; mem_ready=1.
  - Response: mem_re on 0x100..0x103 in 4 consecutive cycles, then done with rdata=0x12345678; stall high 5 cycles.
- **LB vs LBU:**
  - Stimulus: byte 0x80 at 0x20.
  - Response: LB gives rdata=0xFFFFFF80; LBU gives 0x00000080. Each has 2 stall cycles.
- **SH with wait states:**
  - Stimulus: SH addr 0x42, wdata 0xAAAABEEF; mem_ready low for 2 cycles on each byte.
  - Response: writes 0xEF@0x42, then 0xBE@0x43; done after 6 ACCESS cycles; no mem_re.
- **Illegal accesses:**
  - Stimulus: LW addr 0x102, SH addr 0x7, load funct3=3, and MemRead=MemWrite=1.
  - Response: each gives done=err=1 one cycle after the request, rdata=0, and zero mem_re/mem_we activity.
- **Reset mid-SW:**
  - Stimulus: SW addr 0x0, wdata 0x11223344; rst_n=0 after the second byte.
  - Response: only 0x44@0x0 and 0x33@0x1 are written; all outputs are 0 next cycle; FSM in IDLE.
- **Back-to-back:**
  - Stimulus: SB 0x55@0x10 immediately followed by LBU 0x10.
  - Response: one IDLE cycle between done and the next mem_re; rdata=0x00000055.

Source files
------------

// File: rtl/mem_access_unit.sv
// mem_access_unit: sequences LB/LH/LW/LBU/LHU loads and SB/SH/SW stores as
// little-endian byte transactions on a byte-wide memory with a ready handshake,
// holding the pipeline in stall until the access completes. Illegal or
// misaligned requests finish in one cycle with err set and never touch memory.
module mem_access_unit #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              stall,
  output logic              done,
  output logic              err,
  output logic [31:0]       rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_re,
  output logic              mem_we,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_ready
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [ADDR_W-1:0]   a_addr;
  logic [DATA_W-1:0]   a_wdata;
  logic [2:0]          a_f3;
  logic                a_load;
  logic [DATA_W-1:0]   rbuf;
  logic                done_q;
  logic                err_q;

  logic                req;
  logic                illegal;
  logic                last_byte;
  logic                in_access;
  logic [DATA_W-1:0]   merged;
  logic [BYTE_W-1:0]   wbyte;

  // Pick byte lane i out of a word.
  function automatic logic [BYTE_W-1:0] byte_of(input logic [DATA_W-1:0] w,
                                                input logic [CNT_W-1:0]  i);
    logic [BYTE_W-1:0] b;
    b = w[7:0];
    case (i)
      2'd0: b = w[7:0];
      2'd1: b = w[15:8];
      2'd2: b = w[23:16];
      2'd3: b = w[31:24];
      default: b = w[7:0];
    endcase
    return b;
  endfunction

  // Replace byte lane i of a word with b.
  function automatic logic [DATA_W-1:0] lane_insert(input logic [DATA_W-1:0] w,
                                                    input logic [CNT_W-1:0]  i,
                                                    input logic [BYTE_W-1:0] b);
    logic [DATA_W-1:0] r;
    r = w;
    case (i)
      2'd0: r[7:0]   = b;
      2'd1: r[15:8]  = b;
      2'd2: r[23:16] = b;
      2'd3: r[31:24] = b;
      default: r = w;
    endcase
    return r;
  endfunction

  // Sign- or zero-extend the assembled load data according to funct3.
  function automatic logic [DATA_W-1:0] extend(input logic [2:0]        f3,
                                               input logic [DATA_W-1:0] w);
    logic [DATA_W-1:0] r;
    r = w;
    case (f3)
      3'd0:    r = {{24{w[7]}}, w[7:0]};
      3'd1:    r = {{16{w[15]}}, w[15:0]};
      3'd4:    r = {24'd0, w[7:0]};
      3'd5:    r = {16'd0, w[15:0]};
      default: r = w;
    endcase
    return r;
  endfunction

  // Request decode: presence, legality and alignment.
  always_comb begin
    req     = MemRead | MemWrite;
    illegal = 1'b0;
    if (MemRead && MemWrite) begin
      illegal = 1'b1;
    end
    if (MemRead && (funct3 == 3'd3 || funct3 == 3'd6 || funct3 == 3'd7)) begin
      illegal = 1'b1;
    end
    if (MemWrite && (funct3 > 3'd2)) begin
      illegal = 1'b1;
    end
    if (funct3[1:0] == 2'd1 && addr[0]) begin
      illegal = 1'b1;
    end
    if (funct3[1:0] == 2'd2 && addr[1:0] != 2'd0) begin
      illegal = 1'b1;
    end
  end

  // Byte-sequencing helpers for the access in flight.
  always_comb begin
    last_byte = 1'b0;
    case (a_f3[1:0])
      2'd0:    last_byte = (cnt == 2'd0);
      2'd1:    last_byte = (cnt == 2'd1);
      default: last_byte = (cnt == 2'd3);
    endcase
    merged = lane_insert(rbuf, cnt, mem_rdata);
    wbyte  = byte_of(a_wdata, cnt);
  end

  // Access FSM with latched request, byte counter and load buffer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      a_addr  <= '0;
      a_wdata <= '0;
      a_f3    <= '0;
      a_load  <= 1'b0;
      rbuf    <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            if (illegal) begin
              state  <= DONE;
              done_q <= 1'b1;
              err_q  <= 1'b1;
              rbuf   <= '0;
            end else begin
              state   <= ACCESS;
              cnt     <= '0;
              a_addr  <= addr;
              a_wdata <= wdata;
              a_f3    <= funct3;
              a_load  <= MemRead;
              rbuf    <= '0;
              err_q   <= 1'b0;
            end
          end
        end
        ACCESS: begin
          if (mem_ready) begin
            if (a_load) begin
              rbuf <= last_byte ? extend(a_f3, merged) : merged;
            end
            if (last_byte) begin
              state  <= DONE;
              done_q <= 1'b1;
            end else begin
              cnt <= cnt + 2'd1;
            end
          end
        end
        DONE: begin
          state  <= IDLE;
          done_q <= 1'b0;
          err_q  <= 1'b0;
          cnt    <= '0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Pipeline hold and memory strobes, all forced low while reset is asserted.
  assign in_access = rst_n & (state == ACCESS);
  assign stall     = rst_n & (((state == IDLE) & req) | (state == ACCESS));
  assign mem_re    = in_access & a_load;
  assign mem_we    = in_access & ~a_load;
  assign mem_addr  = in_access ? (a_addr + ADDR_W'(cnt)) : '0;
  assign mem_wdata = (in_access & ~a_load) ? wbyte : '0;
  assign done      = rst_n & done_q;
  assign err       = rst_n & err_q;
  assign rdata     = rst_n ? rbuf : '0;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: a byte memory model with programmable
// wait states, an expected-access queue and an expected-response queue.
module tb_mem_access_unit;

  localparam int unsigned ADDR_W = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              MemRead, MemWrite;
  logic [2:0]        funct3;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic              stall, done, err;
  logic [31:0]       rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              mem_re, mem_we;
  logic [7:0]        mem_rdata;
  logic              mem_ready;

  mem_access_unit #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .MemRead(MemRead), .MemWrite(MemWrite),
    .funct3(funct3), .addr(addr), .wdata(wdata), .stall(stall), .done(done),
    .err(err), .rdata(rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_re(mem_re), .mem_we(mem_we), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  typedef struct { logic err; logic [31:0] rdata; } resp_t;
  typedef struct { logic we; logic [31:0] addr; logic [7:0] data; } acc_t;

  resp_t      exp_resp[$];
  acc_t       exp_acc[$];
  logic [7:0] mem [0:511];

  int n_checks = 0, n_fail = 0;
  int wait_states = 0, wcnt = 0;
  int stall_cnt = 0, acc_cnt = 0;
  int cyc = 0, done_cyc = 0, first_acc_cyc = -1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s", name);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: answers each strobed cycle after wait_states idle cycles.
  always @(negedge clk) begin
    acc_t e;
    if (mem_re || mem_we) begin
      acc_cnt++;
      if (first_acc_cyc < 0) first_acc_cyc = cyc;
      check("strobe_exclusive", 32'(mem_re & mem_we), 32'd0);
      if (wcnt >= wait_states) begin
        wcnt      = 0;
        mem_ready = 1'b1;
        if (exp_acc.size() == 0) begin
          fail("unexpected_mem_access");
        end else begin
          e = exp_acc.pop_front();
          check("acc_dir", 32'(mem_we), 32'(e.we));
          check("acc_addr", mem_addr, e.addr);
          if (mem_we) begin
            check("acc_wdata", 32'(mem_wdata), 32'(e.data));
            mem[mem_addr[8:0]] = mem_wdata;
          end else begin
            mem_rdata = mem[mem_addr[8:0]];
          end
        end
      end else begin
        wcnt++;
        mem_ready = 1'b0;
      end
    end else begin
      mem_ready = 1'b0;
      wcnt      = 0;
    end
  end

  // Response monitor: pops the scoreboard on every done pulse.
  always @(negedge clk) begin
    resp_t r;
    if (stall) stall_cnt++;
    if (done) begin
      done_cyc = cyc;
      if (exp_resp.size() == 0) begin
        fail("unexpected_done");
      end else begin
        r = exp_resp.pop_front();
        check("resp_err", 32'(err), 32'(r.err));
        check("resp_rdata", rdata, r.rdata);
        check("stall_in_done", 32'(stall), 32'd0);
      end
    end
  end

  task automatic exp_bytes(input logic we, input logic [31:0] a, input logic [31:0] d, input int n);
    acc_t e;
    for (int i = 0; i < n; i++) begin
      e.we   = we;
      e.addr = a + 32'(i);
      e.data = d[8*i +: 8];
      exp_acc.push_back(e);
    end
  endtask

  task automatic check_quiet(input string name);
    check({name, "_stall"}, 32'(stall), 32'd0);
    check({name, "_done"}, 32'(done), 32'd0);
    check({name, "_err"}, 32'(err), 32'd0);
    check({name, "_rdata"}, rdata, 32'd0);
    check({name, "_mem_addr"}, mem_addr, 32'd0);
    check({name, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
    check({name, "_mem_re"}, 32'(mem_re), 32'd0);
    check({name, "_mem_we"}, 32'(mem_we), 32'd0);
  endtask

  // Issue one request, hold it until done, then drop it after the DONE edge.
  task automatic run_req(input string name, input logic rd, input logic wr,
                         input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                         input int ws, input logic e_err, input logic [31:0] e_rdata,
                         input int e_stall, input int e_acc);
    resp_t r;
    int    lat;
    bit    seen;
    r.err   = e_err;
    r.rdata = e_rdata;
    exp_resp.push_back(r);
    wait_states   = ws;
    stall_cnt     = 0;
    acc_cnt       = 0;
    first_acc_cyc = -1;
    MemRead  = rd;
    MemWrite = wr;
    funct3   = f3;
    addr     = a;
    wdata    = wd;
    seen = 0;
    lat  = 0;
    for (int i = 0; i < 64 && !seen; i++) begin
      @(negedge clk);
      lat++;
      if (done) seen = 1;
    end
    if (!seen) fail({name, "_timeout"});
    @(posedge clk);
    #1;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    check({name, "_stall_cycles"}, 32'(stall_cnt), 32'(e_stall));
    check({name, "_latency"}, 32'(lat), 32'(e_stall + 1));
    check({name, "_access_cycles"}, 32'(acc_cnt), 32'(e_acc));
  endtask

  initial begin
    int prev_done;
    for (int i = 0; i < 512; i++) mem[i] = 8'hAA;
    mem[9'h100] = 8'h78; mem[9'h101] = 8'h56; mem[9'h102] = 8'h34; mem[9'h103] = 8'h12;
    mem[9'h020] = 8'h80; mem[9'h021] = 8'hC3;
    mem_rdata = 8'h00;
    mem_ready = 1'b0;
    rst_n     = 1'b0;
    MemRead   = 1'b1;
    MemWrite  = 1'b0;
    funct3    = 3'd2;
    addr      = 32'h0;
    wdata     = 32'h0;

    // Reset: outputs stay 0 even with a request pending
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    check_quiet("reset");
    @(posedge clk); #1;
    MemRead = 1'b0;
    rst_n   = 1'b1;

    // Loads: endianness and extension
    exp_bytes(1'b0, 32'h100, 32'h0, 4);
    run_req("lw", 1, 0, 3'd2, 32'h100, 32'h0, 0, 1'b0, 32'h12345678, 5, 4);
    exp_bytes(1'b0, 32'h20, 32'h0, 1);
    run_req("lb", 1, 0, 3'd0, 32'h20, 32'h0, 0, 1'b0, 32'hFFFFFF80, 2, 1);
    exp_bytes(1'b0, 32'h20, 32'h0, 1);
    run_req("lbu", 1, 0, 3'd4, 32'h20, 32'h0, 0, 1'b0, 32'h00000080, 2, 1);
    exp_bytes(1'b0, 32'h20, 32'h0, 2);
    run_req("lh", 1, 0, 3'd1, 32'h20, 32'h0, 1, 1'b0, 32'hFFFFC380, 5, 4);
    exp_bytes(1'b0, 32'h20, 32'h0, 2);
    run_req("lhu", 1, 0, 3'd5, 32'h20, 32'h0, 0, 1'b0, 32'h0000C380, 3, 2);

    // Halfword store with two wait states per byte
    exp_bytes(1'b1, 32'h42, 32'hAAAABEEF, 2);
    run_req("sh", 0, 1, 3'd1, 32'h42, 32'hAAAABEEF, 2, 1'b0, 32'h0, 7, 6);
    check("sh_mem42", 32'(mem[9'h042]), 32'h000000EF);
    check("sh_mem43", 32'(mem[9'h043]), 32'h000000BE);
    check("sh_mem44", 32'(mem[9'h044]), 32'h000000AA);

    // Illegal requests: one stall cycle, err, no memory activity
    run_req("lw_mis", 1, 0, 3'd2, 32'h102, 32'h0, 0, 1'b1, 32'h0, 1, 0);
    run_req("sh_mis", 0, 1, 3'd1, 32'h7, 32'h1234, 0, 1'b1, 32'h0, 1, 0);
    run_req("ld_f3_3", 1, 0, 3'd3, 32'h0, 32'h0, 0, 1'b1, 32'h0, 1, 0);
    run_req("rd_and_wr", 1, 1, 3'd2, 32'h0, 32'h0, 0, 1'b1, 32'h0, 1, 0);
    run_req("st_f3_4", 0, 1, 3'd4, 32'h0, 32'h0, 0, 1'b1, 32'h0, 1, 0);
    run_req("lhu_mis", 1, 0, 3'd5, 32'h21, 32'h0, 0, 1'b1, 32'h0, 1, 0);

    // Reset after the second byte of a word store
    exp_bytes(1'b1, 32'h0, 32'h11223344, 2);
    wait_states = 0;
    MemWrite = 1'b1;
    funct3   = 3'd2;
    addr     = 32'h0;
    wdata    = 32'h11223344;
    @(posedge clk); @(posedge clk); @(posedge clk);
    #1;
    rst_n    = 1'b0;
    MemWrite = 1'b0;
    @(negedge clk);
    check_quiet("rst_mid");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_quiet("rst_after");
    check("rst_mem0", 32'(mem[9'h000]), 32'h00000044);
    check("rst_mem1", 32'(mem[9'h001]), 32'h00000033);
    check("rst_mem2", 32'(mem[9'h002]), 32'h000000AA);
    check("rst_mem3", 32'(mem[9'h003]), 32'h000000AA);
    check("rst_pending_acc", 32'(exp_acc.size()), 32'd0);
    @(posedge clk); #1;

    // Back-to-back store then load of the same byte
    exp_bytes(1'b1, 32'h10, 32'h00000055, 1);
    run_req("sb", 0, 1, 3'd0, 32'h10, 32'h00000055, 0, 1'b0, 32'h0, 2, 1);
    prev_done = done_cyc;
    exp_bytes(1'b0, 32'h10, 32'h0, 1);
    run_req("lbu_b2b", 1, 0, 3'd4, 32'h10, 32'h0, 0, 1'b0, 32'h00000055, 2, 1);
    check("b2b_gap", 32'(first_acc_cyc - prev_done), 32'd2);
    check("sb_mem10", 32'(mem[9'h010]), 32'h00000055);

    repeat (2) @(posedge clk);
    check("end_pending_resp", 32'(exp_resp.size()), 32'd0);
    check("end_pending_acc", 32'(exp_acc.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
